axis_frame_len_check: RTL

//  Upstream neighbour of axis_frame_fifo. Counts beats per AXI-stream frame and enforces MIN_LEN/MAX_LEN.

---
 rtl/axis_frame_len_check_pkg.sv | 31 +++
 rtl/axis_frame_len_check.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/axis_frame_len_check_pkg.sv
// ---------------------------------------------------------------------------
// axis_frame_len_check_pkg
//   Private definitions for axis_frame_len_check: the two-state FSM type,
//   the tuser polarity that marks a frame as bad, and the helper that folds
//   the individual bad-frame causes into the single tuser bit on tlast.
//   Not shared with axis_frame_fifo; only the polarity (1 = bad) has to
//   agree with that block's USER_BAD_FRAME_VALUE default.
// ---------------------------------------------------------------------------
package axis_frame_len_check_pkg;

    // PASS    : beats are forwarded to the output register and counted.
    // DISCARD : the frame was truncated; the remainder is swallowed until
    //           its own tlast.
    typedef enum logic [0:0] {
        ST_PASS    = 1'b0,
        ST_DISCARD = 1'b1
    } state_t;

    // tuser value that marks a frame as bad for the downstream frame FIFO.
    localparam logic USER_BAD = 1'b1;

    // Bad-frame flag carried on the last emitted beat of a frame.
    function automatic logic mark_bad(
        input logic in_user,
        input logic short_frame,
        input logic truncated
    );
        return (in_user == USER_BAD) | short_frame | truncated;
    endfunction

endpackage

// File: rtl/axis_frame_len_check.sv
// ---------------------------------------------------------------------------
// axis_frame_len_check
//   Sits in front of axis_frame_fifo. Counts beats per AXI-stream frame and
//   enforces MIN_LEN / MAX_LEN:
//     - frames shorter than MIN_LEN get tuser=1 on their tlast beat;
//     - frames longer than MAX_LEN are cut: beat MAX_LEN leaves with
//       tlast=1, tuser=1 and the rest of the input frame is dropped.
//   A per-frame status pulse (frame_done) with held length / bad /
//   truncated flags feeds the statistics counters.
//
// Ports
//   clk, rst            single clock; asynchronous active-high reset
//   input_axis_*        upstream AXI-stream slave (tdata/tvalid/tready/
//                       tlast/tuser, tuser=1 means bad frame)
//   output_axis_*       downstream AXI-stream master, one register deep,
//                       1-cycle latency, full throughput
//   frame_done          1-cycle pulse when a frame's last beat is loaded
//                       into the output register
//   frame_len           beats emitted for that frame (held)
//   frame_bad           frame short, truncated or input tuser on last beat
//   frame_truncated     frame exceeded MAX_LEN (held)
// ---------------------------------------------------------------------------
module axis_frame_len_check
    import axis_frame_len_check_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 16,
    parameter int MIN_LEN    = 1,
    parameter int MAX_LEN    = 1518
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [DATA_WIDTH-1:0] input_axis_tdata,
    input  logic                  input_axis_tvalid,
    output logic                  input_axis_tready,
    input  logic                  input_axis_tlast,
    input  logic                  input_axis_tuser,

    output logic [DATA_WIDTH-1:0] output_axis_tdata,
    output logic                  output_axis_tvalid,
    input  logic                  output_axis_tready,
    output logic                  output_axis_tlast,
    output logic                  output_axis_tuser,

    output logic                  frame_done,
    output logic [LEN_WIDTH-1:0]  frame_len,
    output logic                  frame_bad,
    output logic                  frame_truncated
);

    localparam logic [LEN_WIDTH-1:0] MIN_L = LEN_WIDTH'(MIN_LEN);
    localparam logic [LEN_WIDTH-1:0] MAX_L = LEN_WIDTH'(MAX_LEN);
    localparam logic [LEN_WIDTH-1:0] ONE_L = LEN_WIDTH'(1);

    state_t                 state;
    state_t                 state_next;
    logic [LEN_WIDTH-1:0]   cnt;
    logic [LEN_WIDTH-1:0]   cnt_next;
    logic [LEN_WIDTH-1:0]   cnt_n;

    logic                   accept;
    logic                   load;
    logic                   end_frame;
    logic                   trunc;
    logic                   short_frame;
    logic                   hit_max;
    logic                   out_last_d;
    logic                   out_user_d;

    // -----------------------------------------------------------------------
    // Handshake and beat indexing
    // -----------------------------------------------------------------------
    // While discarding, nothing is written to the output register, so input
    // beats can be swallowed even when downstream is stalled.
    assign input_axis_tready = (state == ST_DISCARD) | ~output_axis_tvalid | output_axis_tready;
    assign accept            = input_axis_tvalid & input_axis_tready;

    // 1-based index of the beat currently presented at the input.
    assign cnt_n       = cnt + ONE_L;
    assign short_frame = (cnt_n < MIN_L);
    assign hit_max     = (cnt_n == MAX_L);

    // -----------------------------------------------------------------------
    // FSM state and beat counter
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_PASS;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        load       = 1'b0;
        end_frame  = 1'b0;
        trunc      = 1'b0;
        out_last_d = input_axis_tlast;
        out_user_d = input_axis_tuser;

        case (state)
            ST_PASS: begin
                if (accept) begin
                    load = 1'b1;
                    if (input_axis_tlast) begin
                        // A tlast landing exactly on MAX_LEN is a legal frame.
                        end_frame  = 1'b1;
                        out_user_d = mark_bad(input_axis_tuser, short_frame, 1'b0);
                        cnt_next   = '0;
                    end else if (hit_max) begin
                        // Close the frame ourselves and drop what follows.
                        end_frame  = 1'b1;
                        trunc      = 1'b1;
                        out_last_d = 1'b1;
                        out_user_d = USER_BAD;
                        cnt_next   = '0;
                        state_next = ST_DISCARD;
                    end else begin
                        cnt_next = cnt_n;
                    end
                end
            end

            ST_DISCARD: begin
                if (accept && input_axis_tlast) begin
                    state_next = ST_PASS;
                end
            end

            default: begin
                state_next = ST_PASS;
                cnt_next   = '0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Output register
    // -----------------------------------------------------------------------
    // A load only happens when the register is empty or draining this cycle,
    // so contents never change while valid is held against a stalled sink.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            output_axis_tvalid <= 1'b0;
            output_axis_tdata  <= '0;
            output_axis_tlast  <= 1'b0;
            output_axis_tuser  <= 1'b0;
        end else if (load) begin
            output_axis_tvalid <= 1'b1;
            output_axis_tdata  <= input_axis_tdata;
            output_axis_tlast  <= out_last_d;
            output_axis_tuser  <= out_user_d;
        end else if (output_axis_tready) begin
            output_axis_tvalid <= 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Per-frame status
    // -----------------------------------------------------------------------
    // Updated in the same cycle the frame's last beat enters the output
    // register; held until the next frame ends.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_done      <= 1'b0;
            frame_len       <= '0;
            frame_bad       <= 1'b0;
            frame_truncated <= 1'b0;
        end else begin
            frame_done <= end_frame;
            if (end_frame) begin
                frame_len       <= cnt_n;
                frame_bad       <= out_user_d;
                frame_truncated <= trunc;
            end
        end
    end

endmodule
